signal_synchronizer_bus: RTL and testbench
==========================================

Name: signal_synchronizer_bus

Overview:
- Parametrised multi-channel successor to the single-bit two-flop synchronizer.
- Brings WIDTH independent asynchronous level signals into the clk_dst domain through a configurable-depth flop chain.
- Generates per-channel registered rise and fall event pulses.
- Can optionally add a per-channel glitch filter.
- Used wherever board-level or foreign-domain status and control levels enter HLS-generated logic.

Parameters:
- WIDTH, 1, number of independent channels (each bit is synchronised separately; no bus coherency is implied).
- STAGES, 2, synchronizer chain depth. Must be >= 2; elaboration error otherwise.
- RESET_VALUE, {WIDTH{1'b0}}, per-channel level loaded into every chain flop and output on reset.
- FILTER_CYCLES, 4, consecutive stable cycles required before the output changes. Used only when the filter macro is defined. Must be >= 1 in that case.

Ports:
- clk_dst  in  1  destination clock; all state on rising edge.
- rstn_dst  in  1  asynchronous active-low reset; assertion is asynchronous, deassertion is assumed synchronised externally.
- signal_src  in  WIDTH  asynchronous input levels.
- signal_dst  out  WIDTH  synchronised (and optionally filtered) levels.
- rise_pulse  out  WIDTH  one-cycle pulse per channel on a 0->1 change of signal_dst.
- fall_pulse  out  WIDTH  one-cycle pulse per channel on a 1->0 change of signal_dst.
- change_any  out  1  one-cycle pulse when any bit of rise_pulse or fall_pulse is set.

Behaviour:
- Reset (rstn_dst=0, asynchronous):
  - all chain flops and signal_dst = RESET_VALUE;
  - rise_pulse = fall_pulse = 0, change_any = 0;
  - filter counters = 0.
  - Reset release generates no pulse by itself.
- Chain: sync[0] <= signal_src, sync[k] <= sync[k-1], for k = 1..STAGES-1. sync_out = sync[STAGES-1].
- Without filter: signal_dst = sync_out.
  - Latency: a level stable before edge N appears on signal_dst after edge N+STAGES-1 (STAGES edges total).
  - Up to +1 cycle of metastability uncertainty.
- Pulses are registered and computed from the next-state and current-state value of signal_dst:
  - rise_pulse[i] <= next_dst[i] & ~signal_dst[i];
  - fall_pulse[i] <= ~next_dst[i] & signal_dst[i];
  - change_any <= |(next_dst ^ signal_dst).
  - Pulses therefore assert on the same edge that signal_dst changes and last exactly one cycle.
- Simultaneous changes on several channels produce simultaneous pulses on those bits. change_any is a single one-cycle pulse.
- A channel that toggles every cycle at sync_out produces alternating rise/fall pulses, with no pulse lost or merged.
- Reset mid-operation: state is immediately forced to reset values and in-flight edges are discarded. Following release, normal latency applies from the first sampling edge.
- No handshake or backpressure. Pulse consumers must be in clk_dst and sample every cycle.

Optional Feature:
- Macro: SIGNAL_SYNCHRONIZER_BUS_FILTER_EN.
- Defined:
  - Per channel, counter cnt[i] of width $clog2(FILTER_CYCLES+1) and a separate signal_dst register.
  - Each cycle:
    - if sync_out[i] == signal_dst[i]: cnt[i] <= 0;
    - else if cnt[i] == FILTER_CYCLES-1: signal_dst[i] <= sync_out[i], cnt[i] <= 0;
    - else: cnt[i] <= cnt[i]+1.
  - A change must persist FILTER_CYCLES consecutive cycles at sync_out. Latency = STAGES + FILTER_CYCLES edges.
  - Shorter glitches are suppressed and produce no pulses.
- Not defined: no counters, signal_dst = sync_out, FILTER_CYCLES ignored.

Test Plan:
1. WIDTH=4, RESET_VALUE=4'b0101, signal_src=4'b1111, hold rstn_dst=0 -> signal_dst=4'b0101, pulses=0, change_any=0. Release reset -> bits 1,3 rise exactly STAGES cycles later, rise_pulse=4'b1010 for one cycle, no fall pulses.
2. No filter, STAGES=3, signal_src[0] 0->1 before edge N -> signal_dst[0]=1 after edge N+2, rise_pulse[0] and change_any high for that one cycle only.
3. No filter, bit1 0->1 and bit2 1->0 in the same cycle -> rise_pulse=4'b0010 and fall_pulse=4'b0100 on the same cycle, change_any single pulse.
4. Filter defined, FILTER_CYCLES=4, STAGES=2:
   - a 3-cycle high glitch on bit0 -> signal_dst[0] stays 0, no pulses;
   - a 4-cycle high -> signal_dst[0]=1 six edges after the input edge, one rise_pulse.
5. Filter defined, input change with cnt[0]=2, assert rstn_dst asynchronously mid-cycle -> outputs go to RESET_VALUE immediately, cnt=0. After release, a stable input needs full STAGES+FILTER_CYCLES latency.
6. No filter, signal_src[0] toggles every cycle for 8 cycles -> signal_dst[0] follows with STAGES delay, 4 rise and 4 fall pulses alternating, none lost.

Source files
------------

// File: rtl/signal_synchronizer_bus.sv
// signal_synchronizer_bus: WIDTH-channel level synchronizer with rise/fall pulses.
// Optional per-channel glitch filter: define SIGNAL_SYNCHRONIZER_BUS_FILTER_EN.
module signal_synchronizer_bus #(
    parameter int unsigned      WIDTH         = 1,
    parameter int unsigned      STAGES        = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}},
    parameter int unsigned      FILTER_CYCLES = 4
) (
    input  logic             clk_dst,
    input  logic             rstn_dst,
    input  logic [WIDTH-1:0] signal_src,
    output logic [WIDTH-1:0] signal_dst,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse,
    output logic             change_any
);

`ifdef SIGNAL_SYNCHRONIZER_BUS_FILTER_EN
    localparam bit FILTER_ON = 1'b1;
`else
    localparam bit FILTER_ON = 1'b0;
`endif

    generate
        if (STAGES < 2 || (FILTER_ON && FILTER_CYCLES < 1)) begin : g_bad_cfg
            $error("signal_synchronizer_bus: STAGES must be >= 2, FILTER_CYCLES >= 1");
        end
    endgenerate

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] next_dst;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;
    logic             change_q;

    always_ff @(posedge clk_dst or negedge rstn_dst) begin
        if (!rstn_dst) begin
            for (int k = 0; k < STAGES; k++) begin
                sync_q[k] <= RESET_VALUE;
            end
        end else begin
            sync_q[0] <= signal_src;
            for (int k = 1; k < STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync_out = sync_q[STAGES-1];

`ifdef SIGNAL_SYNCHRONIZER_BUS_FILTER_EN
    localparam int unsigned   CW       = $clog2(FILTER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

    logic [CW-1:0]    cnt_q [WIDTH];
    logic [CW-1:0]    cnt_d [WIDTH];
    logic [WIDTH-1:0] dst_q;

    // A channel only commits a new level after it has disagreed for FILTER_CYCLES cycles.
    always_comb begin
        next_dst = dst_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync_out[i] != dst_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    next_dst[i] = sync_out[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_dst or negedge rstn_dst) begin
        if (!rstn_dst) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            dst_q <= RESET_VALUE;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            dst_q <= next_dst;
        end
    end

    assign signal_dst = dst_q;
`else
    assign next_dst   = sync_q[STAGES-2];
    assign signal_dst = sync_out;
`endif

    // Pulses are aligned with the edge on which signal_dst takes its new value.
    always_ff @(posedge clk_dst or negedge rstn_dst) begin
        if (!rstn_dst) begin
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            rise_q   <= next_dst & ~signal_dst;
            fall_q   <= ~next_dst & signal_dst;
            change_q <= |(next_dst ^ signal_dst);
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign change_any = change_q;

endmodule

// File: tb/tb_signal_synchronizer_bus.sv
// Directed bench for signal_synchronizer_bus (plain and filtered builds).
module tb_signal_synchronizer_bus;

    logic       clk;
    logic       rst2_n;
    logic       rst3_n;
    logic [3:0] src2;
    logic [3:0] dst2;
    logic [3:0] rise2;
    logic [3:0] fall2;
    logic       chg2;
    logic [3:0] src3;
    logic [3:0] dst3;
    logic [3:0] rise3;
    logic [3:0] fall3;
    logic       chg3;

    int n_chk;
    int n_pass;

    signal_synchronizer_bus #(
        .WIDTH(4), .STAGES(2), .RESET_VALUE(4'b0101), .FILTER_CYCLES(4)
    ) u_dut2 (
        .clk_dst(clk), .rstn_dst(rst2_n), .signal_src(src2),
        .signal_dst(dst2), .rise_pulse(rise2), .fall_pulse(fall2),
        .change_any(chg2)
    );

    signal_synchronizer_bus #(
        .WIDTH(4), .STAGES(3), .RESET_VALUE(4'b0000), .FILTER_CYCLES(4)
    ) u_dut3 (
        .clk_dst(clk), .rstn_dst(rst3_n), .signal_src(src3),
        .signal_dst(dst3), .rise_pulse(rise3), .fall_pulse(fall3),
        .change_any(chg3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // dut2 held in reset with src=F; release and expect bits 1,3 to rise after lat edges.
    task automatic rel_check(input string tag, input int lat);
        src2 = 4'hF;
        tick();
        tick();
        check({tag, " rst dst"}, dst2, 4'b0101);
        check({tag, " rst rise"}, rise2, 4'h0);
        check({tag, " rst fall"}, fall2, 4'h0);
        check({tag, " rst chg"}, chg2, 1'b0);
        rst2_n = 1'b1;
        for (int e = 1; e <= lat + 1; e++) begin
            tick();
            if (e == lat - 1) begin
                check({tag, " early dst"}, dst2, 4'b0101);
                check({tag, " early rise"}, rise2, 4'h0);
            end
            if (e == lat) begin
                check({tag, " lat dst"}, dst2, 4'hF);
                check({tag, " lat rise"}, rise2, 4'b1010);
                check({tag, " lat fall"}, fall2, 4'h0);
                check({tag, " lat chg"}, chg2, 1'b1);
            end
            if (e == lat + 1) begin
                check({tag, " post rise"}, rise2, 4'h0);
                check({tag, " post chg"}, chg2, 1'b0);
            end
        end
    endtask

    initial begin
        int npulse;
        int nrise;
        int nfall;
        int alt_err;
        bit last_rise;
        logic drv [16];

        n_chk  = 0;
        n_pass = 0;
        rst2_n = 1'b0;
        rst3_n = 1'b0;
        src2   = 4'h0;
        src3   = 4'h0;

`ifdef SIGNAL_SYNCHRONIZER_BUS_FILTER_EN
        rel_check("t1", 6);

        // glitch shorter than FILTER_CYCLES on bit0 is swallowed
        src2 = 4'hE;
        for (int k = 0; k < 12; k++) tick();
        check("t4 settle", dst2, 4'hE);
        npulse = 0;
        src2 = 4'hF;
        for (int k = 0; k < 3; k++) tick();
        src2 = 4'hE;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rise2 != 4'h0 || fall2 != 4'h0 || chg2) npulse++;
        end
        check("t4 glitch dst", dst2, 4'hE);
        check("t4 glitch pulses", npulse, 0);

        // exactly FILTER_CYCLES high passes after STAGES+FILTER_CYCLES edges
        src2 = 4'hF;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e == 4) src2 = 4'hE;
            if (e == 5) begin
                check("t4 e5 dst", dst2, 4'hE);
                check("t4 e5 rise", rise2, 4'h0);
            end
            if (e == 6) begin
                check("t4 e6 dst", dst2, 4'hF);
                check("t4 e6 rise", rise2, 4'h1);
                check("t4 e6 chg", chg2, 1'b1);
            end
            if (e == 7) check("t4 e7 rise", rise2, 4'h0);
        end

        // async reset while bit0 counter sits at 2
        for (int k = 0; k < 12; k++) tick();
        check("t5 settle", dst2, 4'hE);
        src2 = 4'hF;
        for (int k = 0; k < 4; k++) tick();
        check("t5 pre dst", dst2, 4'hE);
        #3;
        rst2_n = 1'b0;
        #1;
        check("t5 async dst", dst2, 4'b0101);
        check("t5 async rise", rise2, 4'h0);
        check("t5 async chg", chg2, 1'b0);
        rel_check("t5", 6);
`else
        rel_check("t1", 2);

        tick();
        tick();
        check("t2 rst dst", dst3, 4'h0);
        rst3_n = 1'b1;
        tick();
        tick();

        src3 = 4'b0001;
        tick();
        check("t2 n dst", dst3, 4'h0);
        tick();
        check("t2 n1 dst", dst3, 4'h0);
        check("t2 n1 rise", rise3, 4'h0);
        tick();
        check("t2 n2 dst", dst3, 4'h1);
        check("t2 n2 rise", rise3, 4'h1);
        check("t2 n2 chg", chg3, 1'b1);
        tick();
        check("t2 n3 rise", rise3, 4'h0);
        check("t2 n3 chg", chg3, 1'b0);

        src3 = 4'b0101;
        for (int k = 0; k < 5; k++) tick();
        src3 = 4'b0011;
        tick();
        tick();
        check("t3 early dst", dst3, 4'b0101);
        check("t3 early rise", rise3, 4'h0);
        tick();
        check("t3 dst", dst3, 4'b0011);
        check("t3 rise", rise3, 4'b0010);
        check("t3 fall", fall3, 4'b0100);
        check("t3 chg", chg3, 1'b1);
        tick();
        check("t3 post chg", chg3, 1'b0);
        check("t3 post fall", fall3, 4'h0);

        for (int k = 0; k < 16; k++) drv[k] = (k < 8) ? logic'(k % 2) : 1'b1;
        nrise = 0;
        nfall = 0;
        alt_err = 0;
        last_rise = 1'b1;
        for (int k = 0; k < 14; k++) begin
            src3[0] = drv[k];
            tick();
            if (k >= 2) check("t6 dst0", dst3[0], drv[k-2]);
            if (rise3[0] && fall3[0]) alt_err++;
            if (rise3[0]) begin
                nrise++;
                if (last_rise) alt_err++;
                last_rise = 1'b1;
            end
            if (fall3[0]) begin
                nfall++;
                if (!last_rise) alt_err++;
                last_rise = 1'b0;
            end
        end
        check("t6 rises", nrise, 4);
        check("t6 falls", nfall, 4);
        check("t6 alternation", alt_err, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
